// File: rtl/demux_2bit_1x4_reg.sv
// Registered 1-to-4 demultiplexer for 2-bit words.
// A producer word {In1,In0} is steered by {S1,S0} into one of four
// single-entry holding registers (A..D). Each channel drains through a
// valid/ack handshake; Count tracks accepted words modulo 16.
module demux_2bit_1x4_reg (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In1,
  input  logic       In0,
  input  logic       S1,
  input  logic       S0,
  input  logic       InValid,
  output logic       InReady,
  output logic       A1,
  output logic       A0,
  output logic       B1,
  output logic       B0,
  output logic       C1,
  output logic       C0,
  output logic       D1,
  output logic       D0,
  output logic       AValid,
  output logic       BValid,
  output logic       CValid,
  output logic       DValid,
  input  logic       AAck,
  input  logic       BAck,
  input  logic       CAck,
  input  logic       DAck,
  output logic [3:0] Count
);

  localparam int NUM_CH = 4;

  // Channel index 0..3 maps to A..D.
  logic [NUM_CH-1:0][1:0] data_q;
  logic [NUM_CH-1:0]      vld_q, vld_d;
  logic [NUM_CH-1:0]      ack;
  logic [NUM_CH-1:0]      load;
  logic [1:0]             sel;
  logic [1:0]             word;
  logic                   accept;
  logic [3:0]             count_q, count_d;

  // Handshake decode: ready looks only at the selected channel, so a full
  // channel elsewhere never stalls the producer. Ack on the selected
  // channel frees its slot in the same cycle.
  always_comb begin
    sel     = {S1, S0};
    word    = {In1, In0};
    ack     = {DAck, CAck, BAck, AAck};
    InReady = !vld_q[sel] || ack[sel];
    accept  = InValid && InReady;
    load    = '0;
    if (accept) load[sel] = 1'b1;
    count_d = count_q + (accept ? 4'd1 : 4'd0);
  end

  // Per-channel valid next state: load sets, ack without load clears,
  // ack on an empty channel falls through harmlessly.
  always_comb begin
    vld_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      vld_d[i] = load[i] || (vld_q[i] && !ack[i]);
  end

  // Channel registers: data only changes on load, so it keeps the last
  // delivered word after the consumer acks.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < NUM_CH; i++)
        if (load[i]) data_q[i] <= word;
    end
  end

  // Accepted-word counter, wraps silently.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign {A1, A0} = data_q[0];
  assign {B1, B0} = data_q[1];
  assign {C1, C0} = data_q[2];
  assign {D1, D0} = data_q[3];
  assign AValid   = vld_q[0];
  assign BValid   = vld_q[1];
  assign CValid   = vld_q[2];
  assign DValid   = vld_q[3];
  assign Count    = count_q;

endmodule

// File: doc/demux_2bit_1x4_reg.md
# demux_2bit_1x4_reg

Registered 1-to-4 demultiplexer for 2-bit words, the distribution-side counterpart of the team's 2-bit 4:1 selector. A producer presents a 2-bit word plus a 2-bit channel select. The block steers the word into one of four single-entry holding registers (channels A–D). Each consumer drains its channel through a valid/acknowledge handshake. A 4-bit wrapping counter records accepted words for debug.

## Interface
- No parameters; data width (2 bits), channel count (4) and counter width (4 bits) are fixed.
- Clk  input  1  system clock; all state updates on rising edge
- Rst  input  1  asynchronous, active-high reset
- In1, In0  input  1 each  incoming data word (In1 = MSB)
- S1, S0  input  1 each  channel select: 00→A, 01→B, 10→C, 11→D
- InValid  input  1  producer has a word on In1/In0 with S1/S0
- InReady  output  1  combinational; block accepts this cycle
- A1, A0 / B1, B0 / C1, C0 / D1, D0  output  1 each  registered channel data (x1 = MSB)
- AValid, BValid, CValid, DValid  output  1 each  channel register holds an undelivered word
- AAck, BAck, CAck, DAck  input  1 each  consumer takes the channel's word this cycle
- Count  output  4  number of accepted words, modulo 16

## Operation
- Accept = InValid && InReady.
- InReady = !Valid[sel] || Ack[sel], where sel = {S1,S0}.
  - A full channel may be reloaded in the same cycle it is acknowledged.
  - InReady depends only on the selected channel; full non-selected channels never stall.
- On accept, the selected channel register loads {In1,In0} and its Valid is set.
- Non-selected channel data registers hold their value.
- Per-channel Valid next state:
  - load && !ack → 1
  - !load && ack && Valid → 0
  - load && ack (Valid=1) → stays 1 with the new data; the old word is counted as delivered
  - ack while Valid=0 → ignored, no state change
- Channel data registers change only on load; they are not cleared on ack and keep the last delivered word.
- Channels are independent: acks on any subset of channels, and a load on one channel, may occur in the same cycle.
- InValid=0 → no load and no count change, regardless of S1/S0.
- Count increments by 1 on every accept and wraps 15→0 with no flag.
- Per-channel state: EMPTY (Valid=0) and FULL (Valid=1).
  - EMPTY→FULL on load.
  - FULL→EMPTY on ack without load.
  - FULL→FULL on ack with load, or on no ack.

## Timing
- Reset (asynchronous, active-high): immediately forces every channel's data to 00, all Valid outputs to 0 and Count to 0.
- While Rst is high, InReady = 1 (all channels read as empty) but no load occurs.
- After reset deasserts, the first rising edge with accept loads normally.
- Reset mid-transfer discards any held words with no delivery.
- Latency: a word accepted at edge N is visible on the channel outputs, with Valid=1, after edge N.
- Consumer ack at edge M makes Valid go 0 after edge M, unless the channel is reloaded at the same edge.
- Throughput: one word per cycle per block. A single channel sustains one word per cycle when its consumer acks every cycle.
- InReady has a combinational path from S1/S0 and the Ack inputs. Channel outputs are registered only.

## Test plan
- Reset check: assert Rst mid-run with all channels full → all data 00, all Valid 0, Count 0 immediately; InReady=1.
- Route sweep: push 10 to A, 01 to B, 11 to C, 10 to D on consecutive cycles, with no acks.
  - Each channel shows its word with Valid=1 one edge later.
  - Count=4.
  - A further push to C (InValid=1, S=10) shows InReady=0; C still holds 11 and Count stays 4.
- Same-cycle ack+load: C full with 11, CAck=1, push 00 to C → InReady=1; C=00, CValid stays 1, Count increments.
- Independent stall: A full and not acked, push 01 to B → accepted; B=01, BValid=1, A unchanged.
- Spurious ack and idle: DAck=1 while DValid=0 → no change. InValid=0 with any select for 5 cycles → no load; Count unchanged.
- Counter wrap: 17 accepts to channel A with AAck=1 every cycle → Count goes 15→0→1; AValid stays 1 throughout.
